// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Holds the FSM state encoding and the operation-select encodings used by
// alu_arbiter and Decode_And_Execute.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_SUB  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

endpackage

// File: rtl/alu_arbiter_decode_and_execute.sv
// Decode_And_Execute: purely combinational 4-bit ALU.
// Ports:
//   rs_i, rt_i  4-bit operands
//   sel_i       3-bit operation select (encodings in alu_arb_pkg)
//   rd_o        4-bit result, wraps mod 16, no carry/borrow
// SHL/SHR shift rs by one bit; PASS forwards rs unchanged.
module Decode_And_Execute
    import alu_arb_pkg::*;
(
    input  logic [3:0] rs_i,
    input  logic [3:0] rt_i,
    input  logic [2:0] sel_i,
    output logic [3:0] rd_o
);

    always_comb begin
        rd_o = 4'd0;
        case (sel_i)
            OP_SUB:  rd_o = rs_i - rt_i;
            OP_ADD:  rd_o = rs_i + rt_i;
            OP_AND:  rd_o = rs_i & rt_i;
            OP_OR:   rd_o = rs_i | rt_i;
            OP_XOR:  rd_o = rs_i ^ rt_i;
            OP_SHL:  rd_o = {rs_i[2:0], 1'b0};
            OP_SHR:  rd_o = {1'b0, rs_i[3:1]};
            OP_PASS: rd_o = rs_i;
            default: rd_o = 4'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two requesters.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req0/req1                  requests, held until granted
//   rs0/rt0/sel0, rs1/rt1/sel1 operands and op select per requester
//   gnt0/gnt1                  one-cycle pulse: request accepted, operands latched
//   done0/done1                one-cycle pulse: rd_out holds this requester's result
//   rd_out                     result register, held until the next capture
//   busy                       high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | sample requests, pick winner, latch its operands
// EXEC  | ALU evaluates latched operands for EXEC_LAT cycles
// DONE  | result in rd_out, done pulse for the granted requester
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int EXEC_LAT  = 1,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] rs0,
    input  logic [3:0] rt0,
    input  logic [3:0] rs1,
    input  logic [3:0] rt1,
    input  logic [2:0] sel0,
    input  logic [2:0] sel1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] rd_out,
    output logic       busy
);

    localparam logic [1:0] CNT_LAST = 2'(EXEC_LAT - 1);

    state_e     state_q, state_d;
    logic       ptr_q,   ptr_d;
    logic       who_q,   who_d;
    logic [1:0] cnt_q,   cnt_d;
    logic [3:0] rs_q,    rs_d;
    logic [3:0] rt_q,    rt_d;
    logic [2:0] sel_q,   sel_d;
    logic [3:0] rd_q,    rd_d;
    logic       gnt0_q,  gnt0_d;
    logic       gnt1_q,  gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       win;
    logic [3:0] alu_rd;

    Decode_And_Execute u_dae (
        .rs_i  (rs_q),
        .rt_i  (rt_q),
        .sel_i (sel_q),
        .rd_o  (alu_rd)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        who_d   = who_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        // Tie goes to ptr; otherwise the single active requester wins.
        win     = (req0 && req1) ? ptr_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = EXEC;
                    cnt_d   = 2'd0;
                    who_d   = win;
                    ptr_d   = ~win;
                    rs_d    = win ? rs1  : rs0;
                    rt_d    = win ? rt1  : rt0;
                    sel_d   = win ? sel1 : sel0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    rd_d    = alu_rd;
                    done0_d = ~who_q;
                    done1_d = who_q;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PRIO_INIT;
            who_q   <= 1'b0;
            cnt_q   <= 2'd0;
            rs_q    <= 4'd0;
            rt_q    <= 4'd0;
            sel_q   <= 3'd0;
            rd_q    <= 4'd0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            who_q   <= who_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign rd_out = rd_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: scoreboard of expected (requester, result) pairs
// checked on every done pulse, plus directed timing checks. A second instance
// with EXEC_LAT=3 covers multi-cycle execution and reset mid-operation.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] rs0, rt0, rs1, rt1;
    logic [2:0] sel0, sel1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [3:0] rd_out;

    logic       c_rst_n;
    logic       c_req0, c_req1;
    logic [3:0] c_rs0, c_rt0, c_rs1, c_rt1;
    logic [2:0] c_sel0, c_sel1;
    logic       c_gnt0, c_gnt1, c_done0, c_done1, c_busy;
    logic [3:0] c_rd;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         who;
        logic [3:0] rd;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.EXEC_LAT(1), .PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .rs0(rs0), .rt0(rt0), .rs1(rs1), .rt1(rt1),
        .sel0(sel0), .sel1(sel1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .rd_out(rd_out), .busy(busy)
    );

    alu_arbiter #(.EXEC_LAT(3), .PRIO_INIT(1'b0)) dut3 (
        .clk(clk), .rst_n(c_rst_n), .req0(c_req0), .req1(c_req1),
        .rs0(c_rs0), .rt0(c_rt0), .rs1(c_rs1), .rt1(c_rt1),
        .sel0(c_sel0), .sel1(c_sel1), .gnt0(c_gnt0), .gnt1(c_gnt1),
        .done0(c_done0), .done1(c_done1), .rd_out(c_rd), .busy(c_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    return a - b;
            3'd1:    return a + b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return {a[2:0], 1'b0};
            3'd6:    return {1'b0, a[3:1]};
            default: return a;
        endcase
    endfunction

    // Scoreboard consumer and per-cycle exclusivity checks on the main instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("gnt_exclusive", 8'(gnt0 & gnt1), 8'd0);
            chk("done_exclusive", 8'(done0 & done1), 8'd0);
            if (done0 || done1) begin
                chk("sb_nonempty", 8'(sb.size() != 0), 8'd1);
                if (sb.size() != 0) begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("done_who", 8'(done1), 8'(e.who));
                    chk("rd_out", 8'(rd_out), 8'(e.rd));
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain", 8'(sb.size() == 0), 8'd1);
    endtask

    task automatic issue(input bit who, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [3:0] exp);
        bit got;
        @(negedge clk);
        if (who) begin req1 = 1'b1; rs1 = a; rt1 = b; sel1 = op; end
        else     begin req0 = 1'b1; rs0 = a; rt0 = b; sel0 = op; end
        sb.push_back('{who: who, rd: exp});
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (who ? gnt1 : gnt0) got = 1'b1;
        end
        chk("gnt_seen", 8'(got), 8'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req0 = 0; req1 = 0;
        rs0 = 0; rt0 = 0; rs1 = 0; rt1 = 0; sel0 = 0; sel1 = 0;
        c_rst_n = 1'b0; c_req0 = 0; c_req1 = 0;
        c_rs0 = 0; c_rt0 = 0; c_rs1 = 0; c_rt1 = 0; c_sel0 = 0; c_sel1 = 0;

        repeat (2) @(negedge clk);
        chk("rst_rd", 8'(rd_out), 8'd0);
        chk("rst_gnt", 8'({gnt0, gnt1}), 8'd0);
        chk("rst_done", 8'({done0, done1}), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        rst_n = 1'b1;
        c_rst_n = 1'b1;

        // Single request with cycle-exact latency.
        @(negedge clk);
        req0 = 1'b1; rs0 = 4'd3; rt0 = 4'd4; sel0 = 3'b001;
        sb.push_back('{who: 1'b0, rd: 4'd7});
        @(negedge clk);
        chk("t1_gnt0", 8'(gnt0), 8'd1);
        chk("t1_gnt1", 8'(gnt1), 8'd0);
        chk("t1_busy", 8'(busy), 8'd1);
        chk("t1_done_early", 8'(done0), 8'd0);
        req0 = 1'b0;
        @(negedge clk);
        chk("t1_done0", 8'(done0), 8'd1);
        chk("t1_done1", 8'(done1), 8'd0);
        chk("t1_rd", 8'(rd_out), 8'd7);
        @(negedge clk);
        chk("t1_idle", 8'(busy), 8'd0);
        chk("t1_done_once", 8'(done0), 8'd0);

        // Wrap-around cases.
        issue(1'b1, 4'd2, 4'd5, 3'b000, 4'd13);
        issue(1'b0, 4'd9, 4'd9, 3'b001, 4'd2);
        repeat (3) @(negedge clk);
        chk("rd_hold", 8'(rd_out), 8'd2);

        // All op selects.
        for (int op = 0; op < 8; op++) begin
            logic [3:0] a, b;
            a = 4'(op * 3 + 5);
            b = 4'(op + 6);
            issue(1'b0, a, b, 3'(op), model(3'(op), a, b));
        end

        // Tie from reset; first sampling edge after release is live.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_rd", 8'(rd_out), 8'd0);
        rst_n = 1'b1;
        req0 = 1'b1; rs0 = 4'd1; rt0 = 4'd1; sel0 = 3'b001;
        req1 = 1'b1; rs1 = 4'd8; rt1 = 4'd3; sel1 = 3'b000;
        for (int i = 0; i < 4; i++) sb.push_back('{who: 1'(i % 2), rd: (i % 2 == 0) ? 4'd2 : 4'd5});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt0", 8'(gnt0), 8'(i % 2 == 0));
            chk("rr_gnt1", 8'(gnt1), 8'(i % 2 == 1));
            if (i < 3) repeat (2) @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
        drain();

        // Operands latched at grant; request during EXEC waits for IDLE.
        @(negedge clk);
        req0 = 1'b1; rs0 = 4'd3; rt0 = 4'd4; sel0 = 3'b001;
        sb.push_back('{who: 1'b0, rd: 4'd7});
        @(negedge clk);
        chk("lat_gnt0", 8'(gnt0), 8'd1);
        rs0 = 4'd15; req0 = 1'b0;
        req1 = 1'b1; rs1 = 4'd1; rt1 = 4'd1; sel1 = 3'b001;
        sb.push_back('{who: 1'b1, rd: 4'd2});
        @(negedge clk);
        chk("lat_nogrant_a", 8'(gnt1), 8'd0);
        @(negedge clk);
        chk("lat_nogrant_b", 8'(gnt1), 8'd0);
        @(negedge clk);
        chk("lat_gnt1", 8'(gnt1), 8'd1);
        req1 = 1'b0;
        drain();

        // EXEC_LAT=3: latency, then reset mid-EXEC.
        @(negedge clk);
        c_req0 = 1'b1; c_rs0 = 4'd3; c_rt0 = 4'd4; c_sel0 = 3'b001;
        @(negedge clk);
        chk("l3_gnt0", 8'(c_gnt0), 8'd1);
        c_req0 = 1'b0;
        @(negedge clk);
        chk("l3_nodone_a", 8'(c_done0), 8'd0);
        @(negedge clk);
        chk("l3_nodone_b", 8'(c_done0), 8'd0);
        @(negedge clk);
        chk("l3_done0", 8'(c_done0), 8'd1);
        chk("l3_rd", 8'(c_rd), 8'd7);
        @(negedge clk);
        chk("l3_idle", 8'(c_busy), 8'd0);

        @(negedge clk);
        c_req0 = 1'b1; c_rs0 = 4'd1; c_rt0 = 4'd1;
        @(negedge clk);
        chk("l3b_gnt0", 8'(c_gnt0), 8'd1);
        c_req0 = 1'b0;
        @(negedge clk);
        chk("l3b_busy", 8'(c_busy), 8'd1);
        c_rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", 8'(c_rd), 8'd0);
        chk("mid_rst_busy", 8'(c_busy), 8'd0);
        chk("mid_rst_gnt", 8'({c_gnt0, c_gnt1}), 8'd0);
        chk("mid_rst_done", 8'({c_done0, c_done1}), 8'd0);
        @(negedge clk);
        c_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_nodone", 8'({c_done0, c_done1}), 8'd0);
        end
        c_req0 = 1'b1; c_req1 = 1'b1;
        c_rs1 = 4'd6; c_rt1 = 4'd2; c_sel1 = 3'b000;
        @(negedge clk);
        chk("post_rst_tie0", 8'(c_gnt0), 8'd1);
        chk("post_rst_tie1", 8'(c_gnt1), 8'd0);
        c_req0 = 1'b0; c_req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_done0", 8'(c_done0), 8'd1);
        chk("post_rst_rd", 8'(c_rd), 8'd2);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter EXEC_LAT, default 1: the number of cycles spent in EXEC, legal range 1..4.
REQ-002 The block SHALL have parameter PRIO_INIT, default 0: the requester that wins the first tie after reset.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  request from requester 0/1; held high until that requester's grant.
REQ-006 rs0, rt0, rs1, rt1  input  4 each  operands of requester 0/1.
REQ-007 sel0, sel1  input  3 each  operation select of requester 0/1.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse, request accepted and operands latched.
REQ-009 done0, done1  output  1 each  one-cycle pulse, result for requester 0/1 valid on rd_out.
REQ-010 rd_out  output  4  result register.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-013 In IDLE, requests are sampled at each edge; with any req high, the FSM SHALL go to EXEC, latch the winner's rs/rt/sel, and set the matching gnt for exactly the next cycle.
REQ-014 Arbitration SHALL work as follows:
  - one request high: that requester wins;
  - both high: the requester selected by pointer ptr wins;
  - after each grant to requester i: ptr <= 1-i.
REQ-015 The latched operands SHALL drive one Decode_And_Execute instance; its rd SHALL be captured into rd_out on the edge that ends the EXEC_LAT-th EXEC cycle, and the FSM SHALL then go to DONE.
REQ-016 An EXEC cycle counter SHALL count 0..EXEC_LAT-1 and SHALL clear on entry to EXEC.
REQ-017 In DONE, done_i of the granted requester SHALL be high for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-018 With EXEC_LAT=1, the timing SHALL be:
  - req seen at edge k;
  - gnt in cycle k+1;
  - done in cycle k+2;
  - next acceptance possible at edge k+3.
REQ-019 Requests and operand changes outside IDLE SHALL be ignored.
REQ-020 Dropping req after its grant SHALL NOT cancel the operation.
REQ-021 rd_out SHALL hold its value until the next capture.
REQ-022 gnt0/gnt1 SHALL never be high together, and done0/done1 SHALL never be high together.
REQ-023 Operation encodings SHALL be:
  - 000 SUB: rd = rs - rt, mod 16;
  - 001 ADD: rd = rs + rt, mod 16;
  - others as Decode_And_Execute defines them.
REQ-024 The result SHALL be 4 bits and wrap, with no carry or borrow output.

Reset
REQ-025 rst_n low SHALL immediately force:
  - state = IDLE;
  - ptr = PRIO_INIT;
  - counter = 0;
  - rd_out, gnt0, gnt1, done0, done1, busy all 0;
  - latched operands = 0.
REQ-026 Reset during EXEC or DONE SHALL discard the operation, and no done pulse SHALL follow reset release.
REQ-027 The first edge after rst_n rises SHALL sample requests normally.

Structure
REQ-028 The state encodings (IDLE=2'd0, EXEC=2'd1, DONE=2'd2) and the op encodings (OP_SUB, OP_ADD) SHALL live in the shared package alu_arb_pkg.
REQ-029 The block SHALL contain exactly one sub-module instance, Decode_And_Execute; all other logic SHALL be in alu_arbiter.

Verification
REQ-030 Single request: req0=1, rs0=3, rt0=4, sel0=001 -> gnt0 one cycle later, done0 the cycle after, rd_out=7, gnt1/done1 stay 0.
REQ-031 Wrap: req1=1, rs1=2, rt1=5, sel1=000 -> done1 pulse, rd_out=13; then ADD 9+9 -> rd_out=2.
REQ-032 Tie and round-robin: with PRIO_INIT=0, req0 and req1 held high continuously -> grants alternate 0,1,0,1 every 3 cycles, and each done matches the granted requester.
REQ-033 Latched operands: after gnt0, change rs0 from 3 to 15 -> result still uses 3; raise req1 during EXEC -> no grant until IDLE.
REQ-034 Reset mid-op: assert rst_n=0 during EXEC with EXEC_LAT=3 -> all outputs 0 immediately, no done after release, and the next tie is won by requester 0.
